// File: rtl/imem_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package imem_arbiter_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  // Width of the memory word index for a power-of-two depth.
  function automatic int word_idx_w(input int size_in_words);
    return (size_in_words > 1) ? $clog2(size_in_words) : 1;
  endfunction

endpackage

// File: rtl/imem_arb_starve_ctr.sv
// Saturating count of consecutive loader grants taken while a fetch waits.
module imem_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CW'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == CW'(LIMIT));

endmodule

// File: rtl/imem_arbiter.sv
// Shares one instruction memory between the boot loader and the core fetch port.
// Optional macro IMEM_ARB_MISALIGN_CHK_EN adds op_fetch_misaligned.
//
//   state | meaning
//   BOOT  | loader writes only, core held off, fetches never granted
//   RUN   | core enabled, loader and fetch arbitrated with starvation guard
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int SIZE_IN_WORDS = 1024,
  parameter int STARVE_LIMIT  = 4,
  localparam int W            = word_idx_w(SIZE_IN_WORDS)
) (
  input  logic          ip_clk,
  input  logic          ip_reset,
  input  logic          ip_inst_req,
  input  logic [31:0]   ip_inst_addr,
  output logic          op_inst_valid,
  output logic [31:0]   op_inst,
  output logic [31:0]   op_inst_addr,
  input  logic          ip_ldr_req,
  input  logic [31:0]   ip_ldr_addr,
  input  logic [31:0]   ip_ldr_data,
  output logic          op_ldr_ack,
  input  logic          ip_ldr_done,
  output logic          op_core_en,
  output logic [W-1:0]  op_mem_addr,
  output logic          op_mem_wen,
  output logic [31:0]   op_mem_wdata,
`ifdef IMEM_ARB_MISALIGN_CHK_EN
  output logic          op_fetch_misaligned,
`endif
  input  logic [31:0]   ip_mem_rdata
);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  logic        w_fetch_gnt;
  logic        w_ldr_gnt;
  logic        w_at_limit;
  logic        r_pend;
  logic [31:0] r_fetch_addr;
  logic        w_unused_bits;

  always_ff @(posedge ip_clk) begin
    if (ip_reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grants are gated by reset so the memory port is quiet during reset.
  always_comb begin
    w_state_nxt  = r_state;
    w_fetch_gnt  = 1'b0;
    w_ldr_gnt    = 1'b0;
    op_mem_addr  = ip_inst_addr[W+1:2];
    op_mem_wdata = '0;
    if (!ip_reset) begin
      if ((r_state == RUN) && ip_inst_req && (!ip_ldr_req || w_at_limit)) begin
        w_fetch_gnt = 1'b1;
      end else if (ip_ldr_req) begin
        w_ldr_gnt    = 1'b1;
        op_mem_addr  = ip_ldr_addr[W+1:2];
        op_mem_wdata = ip_ldr_data;
      end
      if ((r_state == BOOT) && ip_ldr_done) begin
        w_state_nxt = RUN;
      end
    end
  end

  assign op_mem_wen = w_ldr_gnt;
  assign op_ldr_ack = w_ldr_gnt;
  assign op_core_en = (r_state == RUN);

  imem_arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .i_clk     (ip_clk),
    .i_reset   (ip_reset),
    .i_inc     (w_ldr_gnt && ip_inst_req),
    .i_clr     (w_fetch_gnt || !ip_inst_req),
    .o_at_limit(w_at_limit)
  );

  always_ff @(posedge ip_clk) begin
    if (ip_reset) begin
      r_pend       <= 1'b0;
      r_fetch_addr <= '0;
    end else begin
      r_pend <= w_fetch_gnt;
      if (w_fetch_gnt) begin
        r_fetch_addr <= ip_inst_addr;
      end
    end
  end

  // Read data arrives one cycle after the grant; a reset that cycle squashes it.
  assign op_inst_valid = r_pend && !ip_reset;
  assign op_inst       = op_inst_valid ? ip_mem_rdata : '0;
  assign op_inst_addr  = r_fetch_addr;

`ifdef IMEM_ARB_MISALIGN_CHK_EN
  assign op_fetch_misaligned = op_inst_valid && (r_fetch_addr[1:0] != 2'b00);
`endif

  assign w_unused_bits = &{1'b0, ip_ldr_addr[31:W+2], ip_ldr_addr[1:0]};

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a read-first memory model.
module tb_imem_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr_o;
  logic        ldr_req;
  logic [31:0] ldr_addr;
  logic [31:0] ldr_data;
  logic        ldr_ack;
  logic        ldr_done;
  logic        core_en;
  logic [9:0]  mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef IMEM_ARB_MISALIGN_CHK_EN
  logic        misaligned;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:1023];

  imem_arbiter dut (
    .ip_clk      (clk),
    .ip_reset    (reset),
    .ip_inst_req (inst_req),
    .ip_inst_addr(inst_addr),
    .op_inst_valid(inst_valid),
    .op_inst     (inst),
    .op_inst_addr(inst_addr_o),
    .ip_ldr_req  (ldr_req),
    .ip_ldr_addr (ldr_addr),
    .ip_ldr_data (ldr_data),
    .op_ldr_ack  (ldr_ack),
    .ip_ldr_done (ldr_done),
    .op_core_en  (core_en),
    .op_mem_addr (mem_addr),
    .op_mem_wen  (mem_wen),
    .op_mem_wdata(mem_wdata),
`ifdef IMEM_ARB_MISALIGN_CHK_EN
    .op_fetch_misaligned(misaligned),
`endif
    .ip_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read-first memory
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Fetch with no loader contention: grant this cycle, response next cycle.
  task automatic fetch(input string tag, input logic [31:0] a,
                       input logic [31:0] exp_idx, input logic [31:0] exp_data);
    inst_req  = 1'b1;
    inst_addr = a;
    @(negedge clk);
    chk({tag, "_wen"}, {31'd0, mem_wen}, 32'd0);
    chk({tag, "_maddr"}, {22'd0, mem_addr}, exp_idx);
    next_cycle();
    inst_req = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    chk({tag, "_inst"}, inst, exp_data);
    chk({tag, "_iaddr"}, inst_addr_o, a);
`ifdef IMEM_ARB_MISALIGN_CHK_EN
    chk({tag, "_misal"}, {31'd0, misaligned}, {31'd0, (a[1:0] != 2'b00)});
`endif
    next_cycle();
  endtask

  initial begin
    logic [31:0] boot_data [0:2];
    boot_data[0] = 32'h13;
    boot_data[1] = 32'h93;
    boot_data[2] = 32'h113;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    reset = 1'b1; inst_req = 1'b0; inst_addr = '0;
    ldr_req = 1'b0; ldr_addr = '0; ldr_data = '0; ldr_done = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_core_en", {31'd0, core_en}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_ack", {31'd0, ldr_ack}, 32'd0);
    chk("rst_wen", {31'd0, mem_wen}, 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_inst", inst, 32'd0);
    chk("rst_iaddr", inst_addr_o, 32'd0);
    next_cycle();

    // Boot image load
    for (int i = 0; i < 3; i++) begin
      ldr_req  = 1'b1;
      ldr_addr = 32'(i * 4);
      ldr_data = boot_data[i];
      @(negedge clk);
      chk("boot_ack", {31'd0, ldr_ack}, 32'd1);
      chk("boot_wen", {31'd0, mem_wen}, 32'd1);
      chk("boot_maddr", {22'd0, mem_addr}, 32'(i));
      chk("boot_wdata", mem_wdata, boot_data[i]);
      chk("boot_core_en", {31'd0, core_en}, 32'd0);
      next_cycle();
    end
    ldr_req = 1'b0;

    // Fetch in BOOT is never granted
    inst_req = 1'b1; inst_addr = 32'h4;
    @(negedge clk);
    chk("bootf_wen", {31'd0, mem_wen}, 32'd0);
    next_cycle();
    inst_req = 1'b0;
    @(negedge clk);
    chk("bootf_valid", {31'd0, inst_valid}, 32'd0);
    next_cycle();

    ldr_done = 1'b1;
    @(negedge clk);
    chk("done_core_en0", {31'd0, core_en}, 32'd0);
    next_cycle();
    ldr_done = 1'b0;
    @(negedge clk);
    chk("done_core_en1", {31'd0, core_en}, 32'd1);
    next_cycle();

    fetch("f4", 32'h4, 32'd1, 32'h93);
    @(negedge clk);
    chk("idle_valid", {31'd0, inst_valid}, 32'd0);
    chk("idle_ack", {31'd0, ldr_ack}, 32'd0);
    chk("idle_wen", {31'd0, mem_wen}, 32'd0);
    next_cycle();

    // Starvation: loader continuous, fetch 0x8 held
    ldr_req = 1'b1; ldr_addr = 32'h40; ldr_data = 32'hA5;
    inst_req = 1'b1; inst_addr = 32'h8;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stv_ack", {31'd0, ldr_ack}, 32'd1);
      next_cycle();
    end
    @(negedge clk);
    chk("stv_gnt_ack", {31'd0, ldr_ack}, 32'd0);
    chk("stv_gnt_wen", {31'd0, mem_wen}, 32'd0);
    chk("stv_gnt_maddr", {22'd0, mem_addr}, 32'd2);
    next_cycle();
    inst_req = 1'b0;
    @(negedge clk);
    chk("stv_valid", {31'd0, inst_valid}, 32'd1);
    chk("stv_inst", inst, 32'h113);
    chk("stv_ack_resume", {31'd0, ldr_ack}, 32'd1);
    next_cycle();
    ldr_req = 1'b0;

    // Write right after read of the same word returns old data
    inst_req = 1'b1; inst_addr = 32'h0;
    @(negedge clk);
    next_cycle();
    inst_req = 1'b0;
    ldr_req = 1'b1; ldr_addr = 32'h0; ldr_data = 32'hDEAD;
    @(negedge clk);
    chk("raw_valid", {31'd0, inst_valid}, 32'd1);
    chk("raw_old", inst, 32'h13);
    chk("raw_ack", {31'd0, ldr_ack}, 32'd1);
    next_cycle();
    ldr_req = 1'b0;
    fetch("raw_new", 32'h0, 32'd0, 32'hDEAD);

    fetch("wrap", 32'h1004, 32'd1, 32'h93);
    fetch("mis6", 32'h6, 32'd1, 32'h93);

    // Reset the cycle after a fetch grant squashes the response
    inst_req = 1'b1; inst_addr = 32'h8;
    @(negedge clk);
    chk("sq_wen", {31'd0, mem_wen}, 32'd0);
    next_cycle();
    inst_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("sq_valid_rst", {31'd0, inst_valid}, 32'd0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("sq_valid", {31'd0, inst_valid}, 32'd0);
    chk("sq_core_en", {31'd0, core_en}, 32'd0);
    chk("sq_iaddr", inst_addr_o, 32'd0);
    next_cycle();

    // Done coincident with a loader write
    ldr_req = 1'b1; ldr_addr = 32'hC; ldr_data = 32'h55; ldr_done = 1'b1;
    @(negedge clk);
    chk("dc_ack", {31'd0, ldr_ack}, 32'd1);
    chk("dc_core_en0", {31'd0, core_en}, 32'd0);
    next_cycle();
    ldr_req = 1'b0; ldr_done = 1'b0;
    @(negedge clk);
    chk("dc_core_en1", {31'd0, core_en}, 32'd1);
    next_cycle();
    fetch("dc_f", 32'hC, 32'd3, 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
